// File: rtl/memory_responder_pkg.sv
// rtl/memory_responder_pkg.sv - shared types and constants for the memory responder
package memory_responder_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    RESPOND = 2'd2
  } state_t;

  localparam int WORD_WIDTH = 32;

  function automatic int line_offset_width(input int line_words);
    return (line_words > 1) ? $clog2(line_words) : 0;
  endfunction

endpackage

// File: rtl/memory_responder_if.sv
// rtl/memory_responder_if.sv - cache<->memory line request/response bundle
interface memory_responder_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WORDS = 4
);
  import memory_responder_pkg::*;

  logic                               in_req_valid;
  logic                               in_req_write;
  logic [ADDR_WIDTH-1:0]              in_req_addr;
  logic [WORD_WIDTH*LINE_WORDS-1:0]   in_req_wdata;
  logic                               out_req_ready;
  logic                               out_resp_valid;
  logic                               out_resp_write;
  logic [WORD_WIDTH*LINE_WORDS-1:0]   out_resp_rdata;
  logic                               in_resp_ready;
  logic                               out_busy;

  modport master (
    output in_req_valid, in_req_write, in_req_addr, in_req_wdata, in_resp_ready,
    input  out_req_ready, out_resp_valid, out_resp_write, out_resp_rdata, out_busy
  );

  modport slave (
    input  in_req_valid, in_req_write, in_req_addr, in_req_wdata, in_resp_ready,
    output out_req_ready, out_resp_valid, out_resp_write, out_resp_rdata, out_busy
  );

endinterface

// File: rtl/memory_responder_line_storage.sv
// rtl/memory_responder_line_storage.sv - word array with combinational line read and full-line write
module line_storage
  import memory_responder_pkg::*;
#(
  parameter int  LINE_WORDS  = 4,
  parameter int  DEPTH_WORDS = 16384,
  localparam int IDX_W       = $clog2(DEPTH_WORDS),
  localparam int LINE_BITS   = WORD_WIDTH * LINE_WORDS
) (
  input  logic                 clk,
  input  logic                 i_we,
  input  logic [IDX_W-1:0]     i_idx,
  input  logic [LINE_BITS-1:0] i_wdata,
  output logic [LINE_BITS-1:0] o_rdata
);

  // i_idx is always line-aligned, so idx + w never carries into the next line
  logic [WORD_WIDTH-1:0] memory [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int w = 0; w < LINE_WORDS; w++) begin
        memory[i_idx + IDX_W'(w)] <= i_wdata[w*WORD_WIDTH +: WORD_WIDTH];
      end
    end
  end

  always_comb begin
    o_rdata = '0;
    for (int w = 0; w < LINE_WORDS; w++) begin
      o_rdata[w*WORD_WIDTH +: WORD_WIDTH] = memory[i_idx + IDX_W'(w)];
    end
  end

endmodule

// File: rtl/memory_responder.sv
// rtl/memory_responder.sv - fixed-latency main-memory responder for cache line transfers
module memory_responder
  import memory_responder_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int LINE_WORDS  = 4,
  parameter int DEPTH_WORDS = 16384,
  parameter int MEM_LATENCY = 5
) (
  input  logic               clk,
  input  logic               reset,
  memory_responder_if.slave  bus
);

  localparam int IDX_W     = $clog2(DEPTH_WORDS);
  localparam int LINE_BITS = WORD_WIDTH * LINE_WORDS;
  localparam int CNT_W     = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT  = CNT_W'(MEM_LATENCY - 1);
  localparam logic [IDX_W-1:0] LINE_MASK =
    ~((IDX_W'(1) << line_offset_width(LINE_WORDS)) - IDX_W'(1));

  state_t               r_state;
  state_t               w_state_next;
  logic                 r_write;
  logic [IDX_W-1:0]     r_idx;
  logic [LINE_BITS-1:0] r_wdata;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_resp_write;
  logic [LINE_BITS-1:0] r_rdata;

  logic                 w_accept;
  logic                 w_commit;
  logic                 w_release;
  logic                 w_req_ready;
  logic                 w_resp_valid;
  logic                 w_store_we;
  logic [IDX_W-1:0]     w_req_idx;
  logic [LINE_BITS-1:0] w_line_rdata;
  logic                 w_unused_addr;

  // Word index wraps modulo DEPTH_WORDS simply by dropping the high address bits
  assign w_req_idx     = bus.in_req_addr[IDX_W+1:2] & LINE_MASK;
  assign w_unused_addr = ^bus.in_req_addr;

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_commit     = 1'b0;
    w_release    = 1'b0;
    w_req_ready  = 1'b0;
    w_resp_valid = 1'b0;
    case (r_state)
      IDLE: begin
        w_req_ready = 1'b1;
        if (bus.in_req_valid) begin
          w_accept     = 1'b1;
          w_state_next = WAIT;
        end
      end
      WAIT: begin
        if (r_cnt == '0) begin
          w_commit     = 1'b1;
          w_state_next = RESPOND;
        end
      end
      RESPOND: begin
        w_resp_valid = 1'b1;
        if (bus.in_resp_ready) begin
          w_release    = 1'b1;
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // A reset landing on the commit edge must not disturb storage
  assign w_store_we = w_commit && r_write && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_write      <= 1'b0;
      r_idx        <= '0;
      r_wdata      <= '0;
      r_cnt        <= '0;
      r_resp_write <= 1'b0;
      r_rdata      <= '0;
    end else begin
      if (w_accept) begin
        r_write <= bus.in_req_write;
        r_idx   <= w_req_idx;
        r_wdata <= bus.in_req_wdata;
        r_cnt   <= CNT_INIT;
      end else if (r_state == WAIT && r_cnt != '0) begin
        r_cnt <= r_cnt - 1'b1;
      end
      if (w_commit) begin
        r_resp_write <= r_write;
        r_rdata      <= r_write ? '0 : w_line_rdata;
      end else if (w_release) begin
        r_resp_write <= 1'b0;
        r_rdata      <= '0;
      end
    end
  end

  line_storage #(
    .LINE_WORDS  (LINE_WORDS),
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_storage (
    .clk     (clk),
    .i_we    (w_store_we),
    .i_idx   (r_idx),
    .i_wdata (r_wdata),
    .o_rdata (w_line_rdata)
  );

  assign bus.out_req_ready  = w_req_ready;
  assign bus.out_resp_valid = w_resp_valid;
  assign bus.out_resp_write = r_resp_write;
  assign bus.out_resp_rdata = r_rdata;
  assign bus.out_busy       = (r_state != IDLE);

endmodule

// File: tb/tb_memory_responder.sv
// tb/tb_memory_responder.sv - directed and random checks of memory_responder against a line-level model
module tb_memory_responder;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  memory_responder_if #(.ADDR_WIDTH(32), .LINE_WORDS(4)) bus5 ();
  memory_responder_if #(.ADDR_WIDTH(32), .LINE_WORDS(4)) bus1 ();

  memory_responder #(
    .ADDR_WIDTH(32), .LINE_WORDS(4), .DEPTH_WORDS(16384), .MEM_LATENCY(5)
  ) u5 (.clk(clk), .reset(reset), .bus(bus5));

  memory_responder #(
    .ADDR_WIDTH(32), .LINE_WORDS(4), .DEPTH_WORDS(16384), .MEM_LATENCY(1)
  ) u1 (.clk(clk), .reset(reset), .bus(bus1));

  // Reference memories: sparse word maps, one per responder
  logic [31:0] m0 [int unsigned];
  logic [31:0] m1 [int unsigned];

  function automatic int unsigned widx(input logic [31:0] a);
    return ((a >> 2) % 16384) & ~32'd3;
  endfunction

  function automatic logic [127:0] mline(input bit sel, input int unsigned idx);
    logic [127:0] r = '0;
    for (int w = 0; w < 4; w++) r[w*32 +: 32] = sel ? m1[idx + w] : m0[idx + w];
    return r;
  endfunction

  task automatic mwrite(input bit sel, input int unsigned idx, input logic [127:0] d);
    for (int w = 0; w < 4; w++) begin
      if (sel) m1[idx + w] = d[w*32 +: 32];
      else     m0[idx + w] = d[w*32 +: 32];
    end
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drv(input bit sel, input bit v, input bit wr, input logic [31:0] a, input logic [127:0] d);
    if (sel) begin
      bus1.in_req_valid = v; bus1.in_req_write = wr; bus1.in_req_addr = a; bus1.in_req_wdata = d;
    end else begin
      bus5.in_req_valid = v; bus5.in_req_write = wr; bus5.in_req_addr = a; bus5.in_req_wdata = d;
    end
  endtask

  task automatic drv_rr(input bit sel, input bit r);
    if (sel) bus1.in_resp_ready = r;
    else     bus5.in_resp_ready = r;
  endtask

  function automatic logic f_ready(input bit sel);
    return sel ? bus1.out_req_ready : bus5.out_req_ready;
  endfunction
  function automatic logic f_valid(input bit sel);
    return sel ? bus1.out_resp_valid : bus5.out_resp_valid;
  endfunction
  function automatic logic f_write(input bit sel);
    return sel ? bus1.out_resp_write : bus5.out_resp_write;
  endfunction
  function automatic logic f_busy(input bit sel);
    return sel ? bus1.out_busy : bus5.out_busy;
  endfunction
  function automatic logic [127:0] f_rdata(input bit sel);
    return sel ? bus1.out_resp_rdata : bus5.out_resp_rdata;
  endfunction

  task automatic chk_reset_outputs(input bit sel, input string tag);
    chk({tag, ".req_ready"}, f_ready(sel), 1);
    chk({tag, ".resp_valid"}, f_valid(sel), 0);
    chk({tag, ".resp_write"}, f_write(sel), 0);
    chk({tag, ".resp_rdata"}, f_rdata(sel), 0);
    chk({tag, ".busy"}, f_busy(sel), 0);
  endtask

  // One full transaction; optional response stall and an intruding request held while busy
  task automatic txn(input bit sel, input bit wr, input logic [31:0] addr, input logic [127:0] wd,
                     input int hold, input bit intrude, input string tag);
    int unsigned  idx     = widx(addr);
    int           lat_exp = sel ? 1 : 5;
    int           lat;
    logic [127:0] exp_rd;
    exp_rd = wr ? 128'd0 : mline(sel, idx);
    @(negedge clk);
    chk({tag, ".ready_before"}, f_ready(sel), 1);
    drv(sel, 1'b1, wr, addr, wd);
    @(posedge clk);
    @(negedge clk);
    drv(sel, intrude, 1'b1, 32'h0000_3000, {4{32'hdead_beef}});
    chk({tag, ".ready_after_accept"}, f_ready(sel), 0);
    chk({tag, ".busy"}, f_busy(sel), 1);
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end while (!f_valid(sel) && lat < 50);
    chk({tag, ".latency"}, 128'(lat), 128'(lat_exp));
    chk({tag, ".resp_write"}, f_write(sel), wr);
    chk({tag, ".resp_rdata"}, f_rdata(sel), exp_rd);
    if (wr) mwrite(sel, idx, wd);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      @(negedge clk);
      chk({tag, ".hold_valid"}, f_valid(sel), 1);
      chk({tag, ".hold_rdata"}, f_rdata(sel), exp_rd);
      chk({tag, ".hold_ready"}, f_ready(sel), 0);
    end
    drv(sel, 1'b0, 1'b0, 32'd0, 128'd0);
    drv_rr(sel, 1'b1);
    @(posedge clk);
    @(negedge clk);
    drv_rr(sel, 1'b0);
    chk({tag, ".valid_after_release"}, f_valid(sel), 0);
    chk({tag, ".ready_after_release"}, f_ready(sel), 1);
    chk({tag, ".busy_after_release"}, f_busy(sel), 0);
  endtask

  initial begin
    logic [127:0] pre;
    logic [127:0] line_a;
    logic [127:0] line_k;
    logic [31:0]  addr;
    int unsigned  idx;

    pre    = {32'hfff1_0113, 32'h0011_81b3, 32'h0320_0113, 32'h0320_0093};
    line_a = {32'haaaa_0003, 32'haaaa_0002, 32'haaaa_0001, 32'haaaa_0000};
    line_k = {32'h5555_0003, 32'h5555_0002, 32'h5555_0001, 32'h5555_0000};

    reset = 1'b1;
    drv(1'b0, 1'b0, 1'b0, 32'd0, 128'd0);
    drv(1'b1, 1'b0, 1'b0, 32'd0, 128'd0);
    drv_rr(1'b0, 1'b0);
    drv_rr(1'b1, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs(1'b0, "rst5");
    chk_reset_outputs(1'b1, "rst1");
    reset = 1'b0;

    // Program image at word 0x80, then read it back as a line
    txn(1'b0, 1'b1, 32'h0000_0200, pre, 0, 1'b0, "preload");
    chk("preload.mem80", 128'(u5.u_storage.memory[32'h80]), 128'(32'h0320_0093));
    chk("preload.mem83", 128'(u5.u_storage.memory[32'h83]), 128'(32'hfff1_0113));
    txn(1'b0, 1'b0, 32'h0000_0200, 128'd0, 0, 1'b0, "read200");

    txn(1'b0, 1'b1, 32'h0000_0040, {32'd4, 32'd3, 32'd2, 32'd1}, 0, 1'b0, "write40");
    txn(1'b0, 1'b0, 32'h0000_004C, 128'd0, 0, 1'b0, "read4c");
    for (int i = 0; i < 4; i++)
      chk("mem10", 128'(u5.u_storage.memory[32'h10 + i]), 128'(i + 1));

    // Sentinel line that intruding writes would corrupt
    txn(1'b0, 1'b1, 32'h0000_3000, line_k, 0, 1'b0, "sentinel");
    txn(1'b0, 1'b0, 32'h0000_0200, 128'd0, 7, 1'b1, "hold");
    txn(1'b0, 1'b0, 32'h0000_0040, 128'd0, 0, 1'b1, "intrude");
    repeat (3) begin
      @(negedge clk);
      chk("idle_after_intrude.busy", f_busy(1'b0), 0);
      chk("idle_after_intrude.valid", f_valid(1'b0), 0);
    end
    txn(1'b0, 1'b0, 32'h0000_3000, 128'd0, 0, 1'b0, "sentinel_read");

    // Abort a write to word 0x20 two cycles into its latency
    txn(1'b0, 1'b1, 32'h0000_0080, line_a, 0, 1'b0, "write80");
    @(negedge clk);
    drv(1'b0, 1'b1, 1'b1, 32'h0000_0080, {4{32'hbad0_bad0}});
    @(posedge clk);
    @(negedge clk);
    drv(1'b0, 1'b0, 1'b0, 32'd0, 128'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk_reset_outputs(1'b0, "midreset");
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("midreset.mem20", 128'(u5.u_storage.memory[32'h20 + i]), 128'(m0[32'h20 + i]));
      chk("midreset.mem80", 128'(u5.u_storage.memory[32'h80 + i]), 128'(m0[32'h80 + i]));
    end
    txn(1'b0, 1'b0, 32'h0000_0080, 128'd0, 0, 1'b0, "read80_after_abort");

    // Latency-1 instance with an out-of-range address that wraps to word 0
    txn(1'b1, 1'b1, 32'h0000_0000, {32'h1111_0003, 32'h1111_0002, 32'h1111_0001, 32'h1111_0000},
        0, 1'b0, "l1_write0");
    txn(1'b1, 1'b0, 32'h0001_0004, 128'd0, 0, 1'b0, "l1_wrap");

    // Random traffic over six lines with random high and offset address bits
    for (int k = 0; k < 6; k++) begin
      idx  = 32'h100 + 4 * k;
      addr = ($urandom & 32'hFFFF_0000) | (idx << 2) | 32'($urandom_range(0, 15));
      txn(1'b0, 1'b1, addr, {$urandom, $urandom, $urandom, $urandom}, 0, 1'b0, "rnd_init");
    end
    for (int n = 0; n < 24; n++) begin
      idx  = 32'h100 + 4 * $urandom_range(0, 5);
      addr = ($urandom & 32'hFFFF_0000) | (idx << 2) | 32'($urandom_range(0, 15));
      txn(1'b0, 1'($urandom_range(0, 1)), addr, {$urandom, $urandom, $urandom, $urandom},
          $urandom_range(0, 2), 1'b0, "rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
